// File: rtl/wb_host_pkg.sv
// wb_host shared definitions.
// Arbiter state encoding and master indices.
package wb_host_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam logic MSTR_CARAVEL = 1'b0;
    localparam logic MSTR_UART    = 1'b1;

endpackage

// File: rtl/wb_arb_rr2.sv
// Two-way round-robin grant.
// The master that did not win last time has priority on a tie.
module wb_arb_rr2
    import wb_host_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot pick; a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || last == MSTR_UART))
            grant = 2'b01;
        else if (req[1])
            grant = 2'b10;
    end

endmodule

// File: rtl/wb_host_arb.sv
// Two-master Wishbone arbiter with per-transaction timeout.
// Master 0 is Caravel management, master 1 is the UART bridge.
module wb_host_arb
    import wb_host_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 1023,
    parameter int TOW       = 10
)
(
    input  logic            mclk,
    input  logic            reset,

    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_wdat,
    input  logic [DW/8-1:0] m0_sel,
    output logic [DW-1:0]   m0_rdat,
    output logic            m0_ack,
    output logic            m0_err,

    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_wdat,
    input  logic [DW/8-1:0] m1_sel,
    output logic [DW-1:0]   m1_rdat,
    output logic            m1_ack,
    output logic            m1_err,

    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_wdat,
    output logic [DW/8-1:0] s_sel,
    input  logic [DW-1:0]   s_rdat,
    input  logic            s_ack,
    input  logic            s_err,

    output logic [1:0]      gnt,
    output logic            to_flag,
    input  logic            to_clr,
    output logic            to_mstr
);

    localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYCLES - 1);

    logic [1:0]     state;
    logic           last;
    logic [TOW-1:0] cnt;
    logic [1:0]     req;
    logic [1:0]     win;
    logic           g0;
    logic           g1;
    logic           term;
    logic           act_cyc;
    logic           timeout;

    assign req = {m1_cyc & m1_stb, m0_cyc & m0_stb};

    wb_arb_rr2 u_arb (
        .req   (req),
        .last  (last),
        .grant (win)
    );

    // Decode grant, termination and the timeout cycle.
    always_comb begin
        g0      = (state == ST_GNT0);
        g1      = (state == ST_GNT1);
        term    = s_ack | s_err;
        act_cyc = g1 ? m1_cyc : m0_cyc;
        timeout = (g0 | g1) & ~term & (cnt == TO_LAST);
    end

    // Route the granted master to the slave; cut it off on timeout.
    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_adr  = '0;
        s_wdat = '0;
        s_sel  = '0;
        if (g0) begin
            s_cyc  = m0_cyc;
            s_stb  = m0_stb;
            s_we   = m0_we;
            s_adr  = m0_adr;
            s_wdat = m0_wdat;
            s_sel  = m0_sel;
        end else if (g1) begin
            s_cyc  = m1_cyc;
            s_stb  = m1_stb;
            s_we   = m1_we;
            s_adr  = m1_adr;
            s_wdat = m1_wdat;
            s_sel  = m1_sel;
        end
        if (timeout) begin
            s_cyc = 1'b0;
            s_stb = 1'b0;
        end
    end

    // Return path; only the granted master sees the slave.
    always_comb begin
        m0_ack  = g0 & s_ack;
        m0_err  = g0 & (s_err | timeout);
        m0_rdat = g0 ? s_rdat : '0;
        m1_ack  = g1 & s_ack;
        m1_err  = g1 & (s_err | timeout);
        m1_rdat = g1 ? s_rdat : '0;
        gnt     = {g1, g0};
    end

    // Grant FSM with a forced idle cycle between transactions.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            last  <= MSTR_UART;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (win[0]) begin
                        state <= ST_GNT0;
                        last  <= MSTR_CARAVEL;
                    end else if (win[1]) begin
                        state <= ST_GNT1;
                        last  <= MSTR_UART;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    cnt <= cnt + TOW'(1);
                    if (term || !act_cyc || timeout)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky timeout status; a new timeout beats a clear.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            to_flag <= 1'b0;
            to_mstr <= MSTR_CARAVEL;
        end else if (timeout) begin
            to_flag <= 1'b1;
            to_mstr <= g1 ? MSTR_UART : MSTR_CARAVEL;
        end else if (to_clr) begin
            to_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_host_arb.sv
// Scoreboard bench for wb_host_arb.
// Expected terminations are queued at stimulus time.
module tb_wb_host_arb;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 8;
    localparam int TOW = 4;

    logic          mclk = 1'b0;
    logic          reset;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_wdat;
    logic [3:0]    m0_sel;
    logic [DW-1:0] m0_rdat;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_wdat;
    logic [3:0]    m1_sel;
    logic [DW-1:0] m1_rdat;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [3:0]    s_sel;
    logic [DW-1:0] s_rdat;
    logic          s_ack, s_err;
    logic [1:0]    gnt;
    logic          to_flag, to_clr, to_mstr;

    wb_host_arb #(
        .AW(AW), .DW(DW), .TO_CYCLES(TO), .TOW(TOW)
    ) dut (
        .mclk(mclk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
        .m0_adr(m0_adr), .m0_wdat(m0_wdat), .m0_sel(m0_sel),
        .m0_rdat(m0_rdat), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
        .m1_adr(m1_adr), .m1_wdat(m1_wdat), .m1_sel(m1_sel),
        .m1_rdat(m1_rdat), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_adr(s_adr), .s_wdat(s_wdat), .s_sel(s_sel),
        .s_rdat(s_rdat), .s_ack(s_ack), .s_err(s_err),
        .gnt(gnt), .to_flag(to_flag), .to_clr(to_clr),
        .to_mstr(to_mstr)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic        mstr;
        logic        err;
        logic [31:0] rdat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic m, input logic e,
                        input logic [31:0] r);
        exp_t x;
        x.mstr = m;
        x.err  = e;
        x.rdat = r;
        sb.push_back(x);
    endtask

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    task automatic m_set(input int n, input logic c,
                         input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        if (n == 0) begin
            m0_cyc = c; m0_stb = c; m0_we = w;
            m0_adr = a; m0_wdat = d; m0_sel = 4'hf;
        end else begin
            m1_cyc = c; m1_stb = c; m1_we = w;
            m1_adr = a; m1_wdat = d; m1_sel = 4'hf;
        end
    endtask

    // Pop one expectation per termination seen on a master.
    always @(negedge mclk) begin
        if (!reset && (m0_ack | m0_err | m1_ack | m1_err)) begin
            chk("one_term",
                64'((m0_ack | m0_err) ^ (m1_ack | m1_err)), 64'(1));
            if (sb.size() == 0) begin
                chk("unexp_term",
                    64'({m0_ack, m0_err, m1_ack, m1_err}), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("sb_mstr", 64'(m1_ack | m1_err), 64'(mon_e.mstr));
                chk("sb_err", 64'(m0_err | m1_err), 64'(mon_e.err));
                chk("sb_ack", 64'(m0_ack | m1_ack), 64'(!mon_e.err));
                chk("sb_rdat",
                    64'((m1_ack | m1_err) ? m1_rdat : m0_rdat),
                    64'(mon_e.rdat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        to_clr = 1'b0;
        s_ack  = 1'b1;
        s_err  = 1'b0;
        s_rdat = 32'hDEAD_BEEF;
        m_set(0, 1'b0, 1'b0, 32'h0, 32'h0);
        m_set(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        tick;
        @(negedge mclk);
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_flag", 64'(to_flag), 64'(0));
        chk("rst_mstr", 64'(to_mstr), 64'(0));
        chk("rst_scyc", 64'({s_cyc, s_stb}), 64'(0));
        chk("rst_ack", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'(0));
        chk("rst_rdat", 64'(m0_rdat | m1_rdat), 64'(0));
        @(posedge mclk);
        #1;
        s_ack  = 1'b0;
        s_rdat = 32'h0;
        reset  = 1'b0;

        // single master write from the UART side
        m_set(1, 1'b1, 1'b1, 32'h3002_0018, 32'h1122_3344);
        @(negedge mclk);
        chk("t1_idle_stb", 64'(s_stb), 64'(0));
        chk("t1_idle_gnt", 64'(gnt), 64'(0));
        tick;
        @(negedge mclk);
        chk("t1_stb", 64'(s_stb), 64'(1));
        chk("t1_gnt", 64'(gnt), 64'(2));
        chk("t1_adr", 64'(s_adr), 64'(32'h3002_0018));
        chk("t1_wdat", 64'(s_wdat), 64'(32'h1122_3344));
        chk("t1_we", 64'(s_we), 64'(1));
        tick;
        tick;
        s_ack = 1'b1;
        push(1'b1, 1'b0, 32'h0);
        @(negedge mclk);
        chk("t1_m0_ack", 64'(m0_ack), 64'(0));
        tick;
        s_ack = 1'b0;
        m_set(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge mclk);
        chk("t1_gnt_end", 64'(gnt), 64'(0));

        // contention out of reset, both always requesting
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        m_set(0, 1'b1, 1'b0, 32'h3000_00A0, 32'h0);
        m_set(1, 1'b1, 1'b0, 32'h3000_00A1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            logic        em;
            logic [31:0] v;
            em = k[0];
            v  = 32'h5000_0000 + 32'(k);
            push(em, 1'b0, v);
            for (int w = 0; w < 4 && gnt == 2'b00; w++) tick;
            chk("t2_gnt", 64'(gnt), em ? 64'(2) : 64'(1));
            chk("t2_adr", 64'(s_adr),
                em ? 64'(32'h3000_00A1) : 64'(32'h3000_00A0));
            s_rdat = v;
            s_ack  = 1'b1;
            tick;
            s_ack  = 1'b0;
        end
        m_set(0, 1'b0, 1'b0, 32'h0, 32'h0);
        m_set(1, 1'b0, 1'b0, 32'h0, 32'h0);
        s_rdat = 32'h0;
        tick;

        // read path
        m_set(0, 1'b1, 1'b0, 32'h3000_0004, 32'h0);
        tick;
        s_rdat = 32'h6677_8899;
        s_ack  = 1'b1;
        push(1'b0, 1'b0, 32'h6677_8899);
        @(negedge mclk);
        chk("t3_m1_rdat", 64'(m1_rdat), 64'(0));
        chk("t3_m0_rdat", 64'(m0_rdat), 64'(32'h6677_8899));
        tick;
        s_ack  = 1'b0;
        s_rdat = 32'h0;
        m_set(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;

        // slave error is forwarded without raising the flag
        m_set(0, 1'b1, 1'b1, 32'h3000_0008, 32'h0);
        tick;
        s_err = 1'b1;
        push(1'b0, 1'b1, 32'h0);
        tick;
        s_err = 1'b0;
        m_set(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t3_err_flag", 64'(to_flag), 64'(0));
        tick;

        // timeout on the UART master, clear in same cycle loses
        m_set(1, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
        tick;
        for (int i = 1; i <= TO; i++) begin
            if (i == TO) begin
                push(1'b1, 1'b1, 32'h0);
                to_clr = 1'b1;
            end
            @(negedge mclk);
            chk("t4_stb", 64'(s_stb), 64'(i < TO));
            tick;
        end
        to_clr = 1'b0;
        m_set(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t4_flag", 64'(to_flag), 64'(1));
        chk("t4_mstr", 64'(to_mstr), 64'(1));
        chk("t4_gnt", 64'(gnt), 64'(0));
        tick;
        s_ack = 1'b1;
        @(negedge mclk);
        chk("t4_late", 64'({m0_ack, m1_ack}), 64'(0));
        tick;
        s_ack  = 1'b0;
        to_clr = 1'b1;
        tick;
        to_clr = 1'b0;
        chk("t4_clr", 64'(to_flag), 64'(0));

        // ack on the last allowed cycle wins over timeout
        m_set(0, 1'b1, 1'b0, 32'h3000_0014, 32'h0);
        tick;
        for (int i = 1; i < TO; i++) tick;
        s_ack = 1'b1;
        push(1'b0, 1'b0, 32'h0);
        tick;
        s_ack = 1'b0;
        m_set(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t5_flag", 64'(to_flag), 64'(0));
        chk("t5_mstr", 64'(to_mstr), 64'(1));
        tick;

        // abort by master 0
        m_set(0, 1'b1, 1'b1, 32'h3000_0020, 32'h0);
        tick;
        @(negedge mclk);
        chk("t6_cyc", 64'(s_cyc), 64'(1));
        tick;
        m_set(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge mclk);
        chk("t6_abort", 64'(s_cyc), 64'(0));
        tick;
        chk("t6_gnt", 64'(gnt), 64'(0));

        // reset in the middle of a master 1 access
        m_set(1, 1'b1, 1'b0, 32'h3000_0024, 32'h0);
        tick;
        tick;
        @(negedge mclk);
        chk("t7_gnt", 64'(gnt), 64'(2));
        #1;
        s_ack = 1'b1;
        reset = 1'b1;
        #1;
        chk("t7_rst_gnt", 64'(gnt), 64'(0));
        chk("t7_rst_cyc", 64'({s_cyc, s_stb}), 64'(0));
        chk("t7_rst_ack", 64'({m0_ack, m1_ack}), 64'(0));
        @(posedge mclk);
        #1;
        s_ack = 1'b0;
        reset = 1'b0;
        m_set(0, 1'b1, 1'b0, 32'h3000_0028, 32'h0);
        @(negedge mclk);
        chk("t7_idle", 64'(gnt), 64'(0));
        tick;
        chk("t7_win", 64'(gnt), 64'(1));
        s_ack = 1'b1;
        push(1'b0, 1'b0, 32'h0);
        tick;
        s_ack = 1'b0;
        m_set(0, 1'b0, 1'b0, 32'h0, 32'h0);
        m_set(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        tick;

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
